core_fetch: RTL and testbench

Instruction fetch unit for the RISC-V core. It owns the PC, issues one word-aligned request at a time to instruction memory over a valid/ready request channel with an in-order response channel, and buffers the returned word. It presents each instruction and its PC to decode with a valid/ready handshake. It consumes the branch/jump redirect produced downstream by control and execute, discarding stale in-flight fetches when a redirect arrives.

---
 rtl/core_fetch.sv | 104 ++++++++++
 tb/tb_core_fetch.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/core_fetch.sv
`default_nettype none
// ============================================================================
// Module   : core_fetch
// Purpose  : single-outstanding instruction fetch with one-entry output buffer
// Revision : 1.0
// ============================================================================
module core_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_valid,
    output logic [31:0] imem_req_addr,
    input  logic        imem_req_ready,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    output logic        inst_valid,
    output logic [31:0] inst_o,
    output logic [31:0] inst_pc_o,
    input  logic        inst_ready,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic [31:0] fetch_count_o
);

    typedef enum logic [1:0] {
        REQ  = 2'd0,
        WAIT = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t      state;
    logic [31:0] pc;
    logic        drop;
    logic [31:0] inst_buf;
    logic [31:0] pc_buf;
    logic [31:0] fetch_count;
    logic [31:0] target;

    assign target = redirect_pc_i & ~32'h0000_0003;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= REQ;
            pc          <= RESET_PC;
            drop        <= 1'b0;
            inst_buf    <= 32'h0;
            pc_buf      <= 32'h0;
            fetch_count <= 32'h0;
        end else begin
            case (state)
                REQ: begin
                    if (imem_req_ready) begin
                        state  <= WAIT;
                        pc_buf <= pc;
                        // request for the old pc is already out; its word must be discarded
                        if (redirect_i) drop <= 1'b1;
                    end
                    if (redirect_i) pc <= target;
                end
                WAIT: begin
                    if (imem_rsp_valid) begin
                        if (redirect_i) begin
                            pc    <= target;
                            drop  <= 1'b0;
                            state <= REQ;
                        end else if (drop) begin
                            drop  <= 1'b0;
                            state <= REQ;
                        end else begin
                            inst_buf <= imem_rsp_data;
                            pc       <= pc_buf + 32'd4;
                            state    <= HOLD;
                        end
                    end else if (redirect_i) begin
                        pc   <= target;
                        drop <= 1'b1;
                    end
                end
                HOLD: begin
                    if (inst_ready) begin
                        fetch_count <= fetch_count + 32'd1;
                        state       <= REQ;
                    end
                    if (redirect_i) begin
                        pc    <= target;
                        state <= REQ;
                    end
                end
                default: state <= REQ;
            endcase
        end
    end

    // Outputs are forced to their idle values while reset is held.
    assign imem_req_valid = (state == REQ) && !rst;
    assign imem_req_addr  = rst ? RESET_PC : pc;
    assign inst_valid     = (state == HOLD) && !rst;
    assign inst_o         = rst ? 32'h0 : inst_buf;
    assign inst_pc_o      = rst ? 32'h0 : pc_buf;
    assign fetch_count_o  = rst ? 32'h0 : fetch_count;

endmodule
`default_nettype wire

// File: tb/tb_core_fetch.sv
`default_nettype none
// ============================================================================
// Module   : tb_core_fetch
// Purpose  : directed scoreboard bench for core_fetch
// Revision : 1.0
// ============================================================================
module tb_core_fetch;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req_ready;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        inst_ready;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;

    logic        d_req_valid, w_req_valid;
    logic [31:0] d_req_addr, w_req_addr;
    logic        d_inst_valid, w_inst_valid;
    logic [31:0] d_inst, w_inst;
    logic [31:0] d_inst_pc, w_inst_pc;
    logic [31:0] d_count, w_count;

    exp_t        exp_q[$];
    logic [31:0] req_q[$];
    int          n_vec = 0;
    int          n_err = 0;
    int          cyc = 0;
    int          acc_cyc = 0;
    logic [31:0] last_addr;

    always #5 clk = ~clk;

    core_fetch #(.RESET_PC(32'h0000_0100)) u_dut (
        .clk(clk), .rst(rst),
        .imem_req_valid(d_req_valid), .imem_req_addr(d_req_addr), .imem_req_ready(imem_req_ready),
        .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
        .inst_valid(d_inst_valid), .inst_o(d_inst), .inst_pc_o(d_inst_pc), .inst_ready(inst_ready),
        .redirect_i(redirect_i), .redirect_pc_i(redirect_pc_i), .fetch_count_o(d_count)
    );

    core_fetch #(.RESET_PC(32'hFFFF_FFFC)) u_wrap (
        .clk(clk), .rst(rst),
        .imem_req_valid(w_req_valid), .imem_req_addr(w_req_addr), .imem_req_ready(imem_req_ready),
        .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
        .inst_valid(w_inst_valid), .inst_o(w_inst), .inst_pc_o(w_inst_pc), .inst_ready(inst_ready),
        .redirect_i(redirect_i), .redirect_pc_i(redirect_pc_i), .fetch_count_o(w_count)
    );

    function automatic logic [31:0] word_at(input logic [31:0] a);
        return a ^ 32'hC0DE_0013;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_vec++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    task automatic reset_all();
        rst = 1'b1;
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 32'h0;
        inst_ready     = 1'b0;
        redirect_i     = 1'b0;
        redirect_pc_i  = 32'h0;
        exp_q.delete();
        req_q.delete();
        step();
        step();
        chk("rst_req_valid", {31'h0, d_req_valid}, 32'd0);
        chk("rst_req_addr", d_req_addr, 32'h100);
        chk("rst_inst_valid", {31'h0, d_inst_valid}, 32'd0);
        chk("rst_inst", d_inst, 32'h0);
        chk("rst_inst_pc", d_inst_pc, 32'h0);
        chk("rst_count", d_count, 32'h0);
        rst = 1'b0;
        #1;
        chk("post_rst_valid", {31'h0, d_req_valid}, 32'd1);
        chk("post_rst_addr", d_req_addr, 32'h100);
    endtask

    task automatic accept_req(input int stall, input logic redir, input logic [31:0] tgt);
        logic [31:0] exp_addr;
        int guard;
        exp_addr = 32'hxxxx_xxxx;
        if (req_q.size() > 0) exp_addr = req_q.pop_front();
        guard = 0;
        while (!d_req_valid && guard < 20) begin
            step();
            guard++;
        end
        chk("req_valid", {31'h0, d_req_valid}, 32'd1);
        chk("req_addr", d_req_addr, exp_addr);
        for (int i = 0; i < stall; i++) begin
            step();
            chk("stall_valid", {31'h0, d_req_valid}, 32'd1);
            chk("stall_addr", d_req_addr, exp_addr);
        end
        imem_req_ready = 1'b1;
        redirect_i     = redir;
        redirect_pc_i  = tgt;
        last_addr      = exp_addr;
        acc_cyc        = cyc;
        step();
        imem_req_ready = 1'b0;
        redirect_i     = 1'b0;
        chk("no_req_in_wait", {31'h0, d_req_valid}, 32'd0);
    endtask

    task automatic respond(input logic [31:0] data, input int lat, input logic present);
        for (int i = 1; i < lat; i++) begin
            step();
            chk("wait_no_inst", {31'h0, d_inst_valid}, 32'd0);
        end
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = data;
        if (present) exp_q.push_back('{pc: last_addr, inst: data});
        step();
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 32'h0;
        if (!present) chk("dropped_not_shown", {31'h0, d_inst_valid}, 32'd0);
    endtask

    task automatic take_inst(input int stall, input logic redir, input logic [31:0] tgt);
        exp_t e;
        int guard;
        e = '{pc: 32'hxxxx_xxxx, inst: 32'hxxxx_xxxx};
        guard = 0;
        while (!d_inst_valid && guard < 20) begin
            step();
            guard++;
        end
        chk("inst_valid", {31'h0, d_inst_valid}, 32'd1);
        if (exp_q.size() > 0) e = exp_q.pop_front();
        chk("inst_pc", d_inst_pc, e.pc);
        chk("inst_word", d_inst, e.inst);
        for (int i = 0; i < stall; i++) begin
            step();
            chk("hold_valid", {31'h0, d_inst_valid}, 32'd1);
            chk("hold_word", d_inst, e.inst);
            chk("hold_pc", d_inst_pc, e.pc);
            chk("hold_no_req", {31'h0, d_req_valid}, 32'd0);
        end
        inst_ready    = 1'b1;
        redirect_i    = redir;
        redirect_pc_i = tgt;
        step();
        inst_ready = 1'b0;
        redirect_i = 1'b0;
    endtask

    initial begin
        int prev;
        reset_all();
        chk("wrap_first_addr", w_req_addr, 32'hFFFF_FFFC);

        // Back-to-back fetch at minimum latency
        prev = 0;
        for (int i = 0; i < 3; i++) begin
            req_q.push_back(32'h100 + 32'(4 * i));
            accept_req(0, 1'b0, 32'h0);
            if (i > 0) chk("fetch_spacing", 32'(acc_cyc - prev), 32'd3);
            prev = acc_cyc;
            respond(word_at(last_addr), 1, 1'b1);
            take_inst(0, 1'b0, 32'h0);
            if (i == 0) chk("wrap_second_addr", w_req_addr, 32'h0000_0000);
        end
        chk("count_after_3", d_count, 32'd3);

        // Backpressure on both channels
        reset_all();
        req_q.push_back(32'h100);
        accept_req(4, 1'b0, 32'h0);
        respond(word_at(last_addr), 2, 1'b1);
        take_inst(5, 1'b0, 32'h0);
        chk("count_bp", d_count, 32'd1);

        // Redirect during HOLD together with the handshake
        req_q.push_back(32'h104);
        accept_req(0, 1'b0, 32'h0);
        respond(word_at(last_addr), 1, 1'b1);
        take_inst(0, 1'b1, 32'h200);
        chk("count_hold_redir", d_count, 32'd2);
        req_q.push_back(32'h200);
        accept_req(0, 1'b0, 32'h0);
        respond(word_at(last_addr), 1, 1'b1);
        take_inst(0, 1'b0, 32'h0);

        // Redirect during WAIT; late word is discarded
        req_q.push_back(32'h204);
        accept_req(0, 1'b0, 32'h0);
        redirect_i    = 1'b1;
        redirect_pc_i = 32'h300;
        step();
        redirect_i = 1'b0;
        chk("wait_redir_no_inst", {31'h0, d_inst_valid}, 32'd0);
        chk("wait_redir_no_req", {31'h0, d_req_valid}, 32'd0);
        step();
        respond(32'hDEAD_BEEF, 2, 1'b0);
        req_q.push_back(32'h300);
        accept_req(0, 1'b0, 32'h0);
        respond(word_at(last_addr), 1, 1'b1);
        take_inst(0, 1'b0, 32'h0);
        chk("count_wait_redir", d_count, 32'd4);

        // Redirect coincident with acceptance of 0x104
        reset_all();
        req_q.push_back(32'h100);
        accept_req(0, 1'b0, 32'h0);
        respond(word_at(last_addr), 1, 1'b1);
        take_inst(0, 1'b0, 32'h0);
        req_q.push_back(32'h104);
        accept_req(0, 1'b1, 32'h40A);
        respond(word_at(32'h104), 2, 1'b0);
        req_q.push_back(32'h408);
        accept_req(0, 1'b0, 32'h0);
        respond(word_at(last_addr), 1, 1'b1);
        take_inst(0, 1'b0, 32'h0);
        chk("count_coincident", d_count, 32'd2);

        // Reset while a response is outstanding
        req_q.push_back(32'h40C);
        accept_req(0, 1'b0, 32'h0);
        rst = 1'b1;
        step();
        chk("rst_wait_valid", {31'h0, d_req_valid}, 32'd0);
        chk("rst_wait_count", d_count, 32'd0);
        rst = 1'b0;
        #1;
        chk("rst_wait_req_valid", {31'h0, d_req_valid}, 32'd1);
        chk("rst_wait_req_addr", d_req_addr, 32'h100);
        chk("rst_wait_inst_valid", {31'h0, d_inst_valid}, 32'd0);
        chk("rst_wait_count2", d_count, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
